// File: rtl/program_table_receiver.sv
// Host byte-stream receiver for the function table: parses a 16-bit count header,
// assembles little-endian entries into table writes and validates an XOR checksum.
module program_table_receiver #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              write_clk,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   entries_loaded
);

  // state   | meaning
  // IDLE    | waiting for start
  // CNT_LO  | receive count low byte
  // CNT_HI  | receive count high byte, range-check the count
  // DATA    | receive BYTES entry bytes, LS byte first
  // WR_HI   | write strobe high, addr/data held
  // WR_LO   | write strobe low, advance address or finish
  // CHECK   | receive and compare checksum byte
  // DONE    | load good; start re-arms
  // ERROR   | overflow or bad checksum; start re-arms

  localparam int BYTES = DATA_W / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_WR_HI, S_WR_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       count, count_nxt;
  logic [BCW-1:0]    byte_cnt, byte_cnt_nxt;
  logic [7:0]        xor_acc, xor_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [ADDR_W:0]   loaded_nxt, loaded_inc;
  logic              done_nxt, error_nxt;
  logic              accept;
  logic [16:0]       hdr_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      count          <= '0;
      byte_cnt       <= '0;
      xor_acc        <= '0;
      write_addr     <= '0;
      write_data     <= '0;
      entries_loaded <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_nxt;
      count          <= count_nxt;
      byte_cnt       <= byte_cnt_nxt;
      xor_acc        <= xor_nxt;
      write_addr     <= addr_nxt;
      write_data     <= data_nxt;
      entries_loaded <= loaded_nxt;
      done           <= done_nxt;
      error          <= error_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    byte_cnt_nxt = byte_cnt;
    xor_nxt      = xor_acc;
    addr_nxt     = write_addr;
    data_nxt     = write_data;
    loaded_nxt   = entries_loaded;
    done_nxt     = done;
    error_nxt    = error;
    rx_ready     = 1'b0;
    busy         = 1'b0;
    write_clk    = 1'b0;

    case (state)
      S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      S_WR_HI: begin
        busy      = 1'b1;
        write_clk = 1'b1;
      end
      S_WR_LO: busy = 1'b1;
      default: ;
    endcase

    accept     = rx_valid && rx_ready;
    hdr_count  = {1'b0, rx_data, count[7:0]};
    loaded_inc = entries_loaded + 1'b1;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_nxt  = S_CNT_LO;
          done_nxt   = 1'b0;
          error_nxt  = 1'b0;
          loaded_nxt = '0;
          addr_nxt   = '0;
          xor_nxt    = '0;
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          count_nxt[7:0] = rx_data;
          xor_nxt        = xor_acc ^ rx_data;
          state_nxt      = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (accept) begin
          count_nxt[15:8] = rx_data;
          xor_nxt         = xor_acc ^ rx_data;
          byte_cnt_nxt    = '0;
          if (hdr_count > DEPTH) begin
            state_nxt = S_ERROR;
            error_nxt = 1'b1;
          end else if (hdr_count == 17'd0) begin
            state_nxt = S_CHECK;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          // shift right so the first byte received ends up in the LS position
          data_nxt = (write_data >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));
          xor_nxt  = xor_acc ^ rx_data;
          if (byte_cnt == BCW'(BYTES - 1)) begin
            state_nxt = S_WR_HI;
          end else begin
            byte_cnt_nxt = byte_cnt + 1'b1;
          end
        end
      end
      S_WR_HI: state_nxt = S_WR_LO;
      S_WR_LO: begin
        loaded_nxt = loaded_inc;
        if (17'(loaded_inc) < {1'b0, count}) begin
          addr_nxt     = write_addr + 1'b1;
          byte_cnt_nxt = '0;
          state_nxt    = S_DATA;
        end else begin
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (rx_data == xor_acc) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_ERROR;
            error_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign write_en = busy;

endmodule

// File: tb/tb_program_table_receiver.sv
// Scoreboard bench for program_table_receiver: a frame-level model predicts the
// writes and final status; a negedge monitor checks every write strobe.
module tb_program_table_receiver;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int BYTES  = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic              clock = 1'b0;
  logic              reset, start, rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready, write_en, write_clk, busy, done, error;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W:0]   entries_loaded;

  int  checks = 0;
  int  errors = 0;
  int  wr_seen = 0;
  wr_t exp_q[$];

  logic              prev_wclk = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_data = '0;

  program_table_receiver #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .write_en(write_en),
    .write_addr(write_addr), .write_data(write_data), .write_clk(write_clk),
    .busy(busy), .done(done), .error(error), .entries_loaded(entries_loaded)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard on every write strobe
  always @(negedge clock) begin
    if (reset) begin
      prev_wclk <= 1'b0;
    end else begin
      if (write_clk) begin
        wr_seen = wr_seen + 1;
        chk("rx_ready_in_wr_hi", rx_ready, 0);
        chk("write_en_in_wr_hi", write_en, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", write_addr, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_addr", write_addr, e.a);
          chk("write_data", write_data, e.d);
        end
      end
      if (prev_wclk) begin
        chk("write_clk_width", write_clk, 0);
        chk("addr_stable", write_addr, prev_addr);
        chk("data_stable", write_data, prev_data);
        chk("rx_ready_in_wr_lo", rx_ready, 0);
      end
      prev_wclk <= write_clk;
      prev_addr <= write_addr;
      prev_data <= write_data;
    end
  end

  // frame-level reference: predicts writes, bytes consumed and final status
  task automatic model(input bq_t fr, output int consumed, output bit e_done,
                       output bit e_err, output int e_ent);
    int cnt;
    logic [7:0] x;
    cnt = int'({fr[1], fr[0]});
    e_done = 0; e_err = 0; e_ent = 0;
    if (cnt > DEPTH) begin
      consumed = 2;
      e_err    = 1;
    end else begin
      x = 8'h00;
      for (int i = 0; i < 2 + cnt * BYTES; i++) x ^= fr[i];
      for (int i = 0; i < cnt; i++) begin
        wr_t w;
        w.a = ADDR_W'(i);
        w.d = '0;
        for (int b = 0; b < BYTES; b++) w.d[b*8 +: 8] = fr[2 + i*BYTES + b];
        exp_q.push_back(w);
      end
      consumed = 2 + cnt * BYTES + 1;
      e_ent    = cnt;
      e_done   = (fr[consumed-1] == x);
      e_err    = !e_done;
    end
  endtask

  function automatic bq_t make_frame(input int n, input bit bad);
    bq_t f;
    logic [15:0] nn;
    logic [7:0] x, b;
    nn = 16'(n);
    f = {};
    f.push_back(nn[7:0]);
    f.push_back(nn[15:8]);
    for (int i = 0; i < n * BYTES; i++) begin
      b = 8'($urandom_range(0, 255));
      f.push_back(b);
    end
    x = 8'h00;
    foreach (f[i]) x ^= f[i];
    f.push_back(bad ? (x ^ 8'h5A) : x);
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit rnd, output bit ok);
    bit acc;
    ok = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      rx_data  = b;
      rx_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rnd && busy) start = ($urandom_range(0, 7) == 0);
      acc = rx_valid && rx_ready;
      @(posedge clock);
      #1;
      start = 1'b0;
      if (acc) begin
        rx_valid = 1'b0;
        ok = 1;
        return;
      end
    end
    chk("byte_accept_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input string name, input bq_t fr, input bit rnd);
    int consumed, e_ent;
    bit e_done, e_err, ok;
    model(fr, consumed, e_done, e_err, e_ent);
    pulse_start();
    @(negedge clock);
    chk({name, "_busy_after_start"}, busy, 1);
    chk({name, "_cleared_after_start"}, {done, error, 31'(entries_loaded)}, 0);
    for (int i = 0; i < consumed; i++) begin
      send_byte(fr[i], rnd, ok);
      if (!ok) return;
    end
    @(negedge clock);
    if (e_err && consumed == 2) begin
      chk({name, "_err_after_cnt_hi"}, error, 1);
      for (int k = 0; k < 4; k++) begin
        rx_data  = fr[2];
        rx_valid = 1'b1;
        chk({name, "_rx_ready_after_ovf"}, rx_ready, 0);
        @(negedge clock);
      end
      rx_valid = 1'b0;
    end
    chk({name, "_done"}, done, 32'(e_done));
    chk({name, "_error"}, error, 32'(e_err));
    chk({name, "_entries_loaded"}, entries_loaded, e_ent);
    chk({name, "_busy_end"}, {busy, write_en, rx_ready}, 0);
    chk({name, "_pending_writes"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t good, f;
    int  base, consumed, e_ent;
    bit  e_done, e_err, ok;

    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_outputs", {rx_ready, write_en, write_clk, busy, done, error}, 0);
    chk("reset_addr_data", {write_addr, write_data}, 0);
    chk("reset_entries", entries_loaded, 0);

    good = '{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00, 8'h42};
    base = wr_seen;
    run_frame("good", good, 0);
    chk("good_write_count", wr_seen - base, 3);

    run_frame("empty", '{8'h00, 8'h00, 8'h00}, 0);

    f = good;
    f[8] = 8'h43;
    run_frame("badsum", f, 0);

    run_frame("overflow", '{8'h01, 8'h04, 8'h00}, 0);

    base = wr_seen;
    run_frame("backpressure", good, 1);
    chk("bp_write_count", wr_seen - base, 3);

    for (int t = 0; t < 8; t++) begin
      f = make_frame($urandom_range(1, 12), $urandom_range(0, 3) == 0);
      run_frame("random", f, $urandom_range(0, 1) == 1);
    end

    // reset after the second write of a three-entry load
    base = wr_seen;
    model(good, consumed, e_done, e_err, e_ent);
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(good[i], 0, ok);
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      #1;
      if (wr_seen >= base + 2) break;
    end
    chk("midload_writes", wr_seen - base, 2);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("midreset_outputs", {rx_ready, write_en, write_clk, busy, done, error}, 0);
    chk("midreset_addr_data", {write_addr, write_data}, 0);
    chk("midreset_entries", entries_loaded, 0);
    chk("midreset_unwritten", exp_q.size(), 1);
    exp_q.delete();

    base = wr_seen;
    run_frame("full_depth", make_frame(DEPTH, 0), 0);
    chk("full_write_count", wr_seen - base, DEPTH);
    chk("full_last_addr", write_addr, DEPTH - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
